extram_bus_fabric: RTL and testbench

//  Parametrised CPU extram-bus interconnect: decodes the vexriscv extram port onto NSLAVE peripheral

---
 rtl/extram_bus_pkg.sv | 38 +++
 rtl/extram_bus_fabric_irq_sync.sv | 29 ++
 rtl/extram_bus_fabric.sv | 180 ++++++++++++++++++
 tb/tb_extram_bus_fabric.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/extram_bus_pkg.sv
// extram_bus_pkg
// Shared constants for the extram bus fabric: access FSM encoding, the
// read value returned by an aborted access, the peripheral slot map, the
// latched request attributes and the timeout counter sizing helper.
// The optional bus timeout is enabled by defining BUS_TIMEOUT_EN.

package extram_bus_pkg;

    // Access FSM encoding (kept as plain constants for legacy tools)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Read data returned when a slave never releases its wait
    localparam logic [31:0] DEAD_DATA = 32'hFFFF_FFFF;

    // Slot map of the peripherals hanging off the fabric
    localparam int SLOT_SDCARD = 0;
    localparam int SLOT_CDDA   = 1;
    localparam int SLOT_IDE    = 2;

    // Attributes captured from the CPU at the start of an access
    typedef struct packed {
        logic [31:0] wdata;
        logic        oe;
        logic [3:0]  wstrb;
    } req_attr_t;

    // Timeout counter width: wide enough for the limit, clamped to 10..16 bits
    function automatic int tmo_cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        if (w < 10) w = 10;
        if (w > 16) w = 16;
        return w;
    endfunction

endpackage

// File: rtl/extram_bus_fabric_irq_sync.sv
// irq_sync
// Single-bit synchroniser for an asynchronous peripheral interrupt.
// DEPTH flops in series; the level is preserved and delayed by DEPTH cycles.

import extram_bus_pkg::*;

module irq_sync #(
    parameter int DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync
);

    logic [DEPTH-1:0] r_chain;

    // Shift the raw interrupt through the synchroniser chain
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[DEPTH-2:0], i_async};
        end
    end

    assign o_sync = r_chain[DEPTH-1];

endmodule

// File: rtl/extram_bus_fabric.sv
// extram_bus_fabric
// Decodes the CPU extram port onto NSLAVE peripheral slots, registers the
// access attributes, muxes the selected slave's read data back and merges
// the slave stalls into cpu_wait. Interrupts are synchronised per slot.
// Optional feature: define BUS_TIMEOUT_EN to abort accesses whose slave
// holds wait for TIMEOUT cycles.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no access; cpu_cs latches address/data/strobes and slot
// REQ   | slv_cs of the latched slot high, waiting for slv_wait low
// DONE  | result presented, cpu_wait low for this single cycle

import extram_bus_pkg::*;

module extram_bus_fabric #(
    parameter int ADDR_W     = 16,
    parameter int NSLAVE     = 3,
    parameter int SEL_LSB    = 11,
    parameter int SEL_W      = 2,
    parameter int TIMEOUT    = 1023,
    parameter int IRQ_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [ADDR_W-1:0]     i_cpu_a,
    input  logic [31:0]           i_cpu_d_out,
    output logic [31:0]           o_cpu_d_in,
    input  logic                  i_cpu_cs,
    input  logic                  i_cpu_oe,
    input  logic [3:0]            i_cpu_wstrb,
    output logic                  o_cpu_wait,
    output logic [ADDR_W-1:0]     o_slv_a,
    output logic [31:0]           o_slv_d_in,
    output logic                  o_slv_oe,
    output logic [3:0]            o_slv_wstrb,
    output logic [NSLAVE-1:0]     o_slv_cs,
    input  logic [NSLAVE*32-1:0]  i_slv_d_out,
    input  logic [NSLAVE-1:0]     i_slv_wait,
    input  logic [NSLAVE-1:0]     i_slv_irq,
    output logic [NSLAVE-1:0]     o_cpu_irq,
    output logic                  o_bus_err
);

    // Reject parameter sets that cannot be decoded
    if (NSLAVE < 1 || NSLAVE > 2**SEL_W || IRQ_STAGES < 2 || TIMEOUT < 1 ||
        ADDR_W < SEL_LSB + SEL_W) begin : g_param_err
        $error("extram_bus_fabric: illegal parameter set");
    end

    logic [1:0]        r_state;
    logic [SEL_W-1:0]  r_slot;
    logic [ADDR_W-1:0] r_a;
    req_attr_t         r_req;
    logic [31:0]       r_rdata;
    logic              r_err;

    logic [SEL_W-1:0]  w_slot;
    logic              w_mapped;
    logic              w_sel_wait;
    logic [31:0]       w_sel_data;
    logic              w_tmo_tc;

    assign w_slot   = i_cpu_a[SEL_LSB +: SEL_W];
    assign w_mapped = (int'(w_slot) < NSLAVE);

    // Select wait and read data of the latched slot
    always_comb begin
        w_sel_wait = 1'b1;
        w_sel_data = '0;
        for (int k = 0; k < NSLAVE; k++) begin
            if (r_slot == SEL_W'(k)) begin
                w_sel_wait = i_slv_wait[k];
                w_sel_data = i_slv_d_out[32*k +: 32];
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = tmo_cnt_width(TIMEOUT);

    logic [CNT_W-1:0] r_tmo_cnt;

    // Down-counter armed outside REQ, counting stalled REQ cycles to zero
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tmo_cnt <= '0;
        end else if (r_state != ST_REQ) begin
            r_tmo_cnt <= CNT_W'(TIMEOUT - 1);
        end else if (w_sel_wait && (r_tmo_cnt != '0)) begin
            r_tmo_cnt <= r_tmo_cnt - 1'b1;
        end
    end

    // Terminal count: this is the TIMEOUT-th REQ cycle with wait still high
    assign w_tmo_tc = (r_tmo_cnt == '0);
`else
    assign w_tmo_tc = 1'b0;
`endif

    // Access FSM with request latching, read capture and sticky error
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_slot  <= '0;
            r_a     <= '0;
            r_req   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_cpu_cs) begin
                        r_slot      <= w_slot;
                        r_a         <= i_cpu_a;
                        r_req.wdata <= i_cpu_d_out;
                        r_req.oe    <= i_cpu_oe;
                        r_req.wstrb <= i_cpu_wstrb;
                        if (w_mapped) begin
                            r_state <= ST_REQ;
                        end else begin
                            // Nothing lives there: finish at once with zero data
                            r_rdata <= '0;
                            r_err   <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_REQ: begin
                    if (!w_sel_wait) begin
                        if (r_req.oe) begin
                            r_rdata <= w_sel_data;
                        end
                        r_state <= ST_DONE;
                    end else if (w_tmo_tc) begin
                        if (r_req.oe) begin
                            r_rdata <= DEAD_DATA;
                        end
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // One-hot slot select, only while the access is in REQ
    always_comb begin
        o_slv_cs = '0;
        for (int k = 0; k < NSLAVE; k++) begin
            o_slv_cs[k] = (r_state == ST_REQ) && (r_slot == SEL_W'(k));
        end
    end

    assign o_slv_a     = r_a;
    assign o_slv_d_in  = r_req.wdata;
    assign o_slv_oe    = r_req.oe;
    assign o_slv_wstrb = (r_state == ST_REQ) ? r_req.wstrb : 4'b0000;
    assign o_cpu_d_in  = r_rdata;
    assign o_cpu_wait  = i_cpu_cs && (r_state != ST_DONE);
    assign o_bus_err   = r_err;

    for (genvar k = 0; k < NSLAVE; k++) begin : g_irq
        irq_sync #(
            .DEPTH (IRQ_STAGES)
        ) u_irq_sync (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_async (i_slv_irq[k]),
            .o_sync  (o_cpu_irq[k])
        );
    end

endmodule

// File: tb/tb_extram_bus_fabric.sv
// tb_extram_bus_fabric
// Self-checking bench for extram_bus_fabric: vector table, hand sequences
// for back-to-back, timeout/stall, reset and interrupt timing, and random
// accesses against a transaction-level model. Honours BUS_TIMEOUT_EN.

module tb_extram_bus_fabric;

    localparam int ADDR_W     = 16;
    localparam int NSLAVE     = 3;
    localparam int SEL_LSB    = 11;
    localparam int SEL_W      = 2;
    localparam int TIMEOUT    = 15;
    localparam int IRQ_STAGES = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [ADDR_W-1:0]    cpu_a;
    logic [31:0]          cpu_d_out;
    logic [31:0]          cpu_d_in;
    logic                 cpu_cs;
    logic                 cpu_oe;
    logic [3:0]           cpu_wstrb;
    logic                 cpu_wait;
    logic [ADDR_W-1:0]    slv_a;
    logic [31:0]          slv_d_in;
    logic                 slv_oe;
    logic [3:0]           slv_wstrb;
    logic [NSLAVE-1:0]    slv_cs;
    logic [NSLAVE*32-1:0] slv_d_out;
    logic [NSLAVE-1:0]    slv_wait;
    logic [NSLAVE-1:0]    slv_irq;
    logic [NSLAVE-1:0]    cpu_irq;
    logic                 bus_err;

    always #5 clk = ~clk;

    extram_bus_fabric #(
        .ADDR_W     (ADDR_W),
        .NSLAVE     (NSLAVE),
        .SEL_LSB    (SEL_LSB),
        .SEL_W      (SEL_W),
        .TIMEOUT    (TIMEOUT),
        .IRQ_STAGES (IRQ_STAGES)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cpu_a     (cpu_a),
        .i_cpu_d_out (cpu_d_out),
        .o_cpu_d_in  (cpu_d_in),
        .i_cpu_cs    (cpu_cs),
        .i_cpu_oe    (cpu_oe),
        .i_cpu_wstrb (cpu_wstrb),
        .o_cpu_wait  (cpu_wait),
        .o_slv_a     (slv_a),
        .o_slv_d_in  (slv_d_in),
        .o_slv_oe    (slv_oe),
        .o_slv_wstrb (slv_wstrb),
        .o_slv_cs    (slv_cs),
        .i_slv_d_out (slv_d_out),
        .i_slv_wait  (slv_wait),
        .i_slv_irq   (slv_irq),
        .o_cpu_irq   (cpu_irq),
        .o_bus_err   (bus_err)
    );

    int errs   = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] a;
        logic        oe;
        logic [3:0]  ws;
        logic [31:0] wd;
        int          waits;
        int          exp_lat;
        logic [31:0] exp_rd;
        logic [2:0]  exp_cs;
        logic        exp_err;
    } vec_t;

    vec_t        tbl [8];
    logic [31:0] sd  [NSLAVE];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_sdata();
        slv_d_out = {sd[2], sd[1], sd[0]};
    endtask

    // Called at a negedge; returns at the negedge where cpu_wait was seen low
    task automatic do_access(input logic [15:0] a, input logic oe, input logic [3:0] ws,
                             input logic [31:0] wd, input int waits, input int bound,
                             input bit keep, output int lat, output logic [31:0] rd,
                             output logic [2:0] cs_seen, output bit fields_ok,
                             output bit gate_ok, output bit onehot_ok, output int first_cs);
        int n;
        int s;
        logic [2:0] cs;
        s = int'(a[SEL_LSB +: SEL_W]);
        cpu_a = a; cpu_oe = oe; cpu_wstrb = ws; cpu_d_out = wd; cpu_cs = 1'b1;
        slv_wait = '1;
        lat = -1; rd = '0; n = 0; cs_seen = '0;
        fields_ok = 1'b1; gate_ok = 1'b1; onehot_ok = 1'b1; first_cs = -1;
        for (int c = 1; c <= bound; c++) begin
            @(posedge clk);
            @(negedge clk);
            cs = slv_cs;
            cs_seen = cs_seen | cs;
            if (cs != 3'b000) begin
                if (first_cs < 0) first_cs = c;
                if (s >= NSLAVE || cs != (3'b001 << s)) onehot_ok = 1'b0;
                if (slv_a !== a || slv_d_in !== wd || slv_oe !== oe || slv_wstrb !== ws)
                    fields_ok = 1'b0;
            end else if (slv_wstrb !== 4'b0000) begin
                gate_ok = 1'b0;
            end
            if (s < NSLAVE && cs[s]) n++;
            slv_wait = '1;
            if (s < NSLAVE && cs[s] && n > waits) slv_wait[s] = 1'b0;
            if (!cpu_wait) begin
                lat = c;
                rd  = cpu_d_in;
                break;
            end
        end
        if (!keep) cpu_cs = 1'b0;
        slv_wait = '1;
    endtask

    task automatic do_reset();
        rst = 1'b1; cpu_cs = 1'b0; slv_wait = '1; slv_irq = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    int          lat, lat2, first_cs, first_cs2;
    logic [31:0] rd, rd2;
    logic [2:0]  cs_seen, cs_seen2;
    bit          f_ok, g_ok, o_ok;
    logic [31:0] m_rd;
    logic        m_err;
    logic [2:0]  drv [0:40];

    initial begin
        rst = 1'b1; cpu_a = '0; cpu_d_out = '0; cpu_cs = 1'b0; cpu_oe = 1'b0;
        cpu_wstrb = '0; slv_d_out = '0; slv_wait = '1; slv_irq = '0;

        tbl[0] = '{16'h0010, 1'b1, 4'hF, 32'h0000_0000, 0, 2, 32'h1234_5678, 3'b001, 1'b0};
        tbl[1] = '{16'h1004, 1'b1, 4'hF, 32'h0000_0000, 0, 2, 32'hDEAD_BEEF, 3'b100, 1'b0};
        tbl[2] = '{16'h0804, 1'b0, 4'h3, 32'hCAFE_F00D, 5, 7, 32'hDEAD_BEEF, 3'b010, 1'b0};
        tbl[3] = '{16'h0BFC, 1'b1, 4'hF, 32'h0000_0000, 3, 5, 32'hA5A5_0F0F, 3'b010, 1'b0};
        tbl[4] = '{16'h17FF, 1'b0, 4'hF, 32'h1111_2222, 1, 3, 32'hA5A5_0F0F, 3'b100, 1'b0};
        tbl[5] = '{16'h1800, 1'b1, 4'hF, 32'h0000_0000, 0, 1, 32'h0000_0000, 3'b000, 1'b1};
        tbl[6] = '{16'hF800, 1'b0, 4'h5, 32'h5555_AAAA, 0, 1, 32'h0000_0000, 3'b000, 1'b1};
        tbl[7] = '{16'h2000, 1'b1, 4'hF, 32'h0000_0000, 2, 4, 32'h1234_5678, 3'b001, 1'b1};

        sd[0] = 32'h1234_5678; sd[1] = 32'hA5A5_0F0F; sd[2] = 32'hDEAD_BEEF;
        load_sdata();

        do_reset();
        check("rst_cpu_d_in",  cpu_d_in,            32'h0);
        check("rst_slv_cs",    32'(slv_cs),         32'h0);
        check("rst_slv_wstrb", 32'(slv_wstrb),      32'h0);
        check("rst_slv_a",     32'(slv_a),          32'h0);
        check("rst_slv_d_in",  slv_d_in,            32'h0);
        check("rst_slv_oe",    32'(slv_oe),         32'h0);
        check("rst_cpu_irq",   32'(cpu_irq),        32'h0);
        check("rst_bus_err",   32'(bus_err),        32'h0);

        // Slot0 slave never releases wait
`ifdef BUS_TIMEOUT_EN
        do_access(16'h0000, 1'b1, 4'hF, 32'h0, 100000, 200, 1'b0,
                  lat, rd, cs_seen, f_ok, g_ok, o_ok, first_cs);
        check("tmo_latency", 32'(lat),     32'(TIMEOUT + 1));
        check("tmo_data",    rd,           32'hFFFF_FFFF);
        check("tmo_bus_err", 32'(bus_err), 32'h1);
        check("tmo_cs_seen", 32'(cs_seen), 32'h1);
`else
        do_access(16'h0000, 1'b1, 4'hF, 32'h0, 100000, 1000, 1'b1,
                  lat, rd, cs_seen, f_ok, g_ok, o_ok, first_cs);
        check("stall_no_done", 32'(lat),      32'hFFFF_FFFF);
        check("stall_wait",    32'(cpu_wait), 32'h1);
        check("stall_slv_cs",  32'(slv_cs),   32'h1);
        check("stall_bus_err", 32'(bus_err),  32'h0);
`endif
        do_reset();
        check("err_cleared_by_rst", 32'(bus_err), 32'h0);

        for (int i = 0; i < 8; i++) begin
            do_access(tbl[i].a, tbl[i].oe, tbl[i].ws, tbl[i].wd, tbl[i].waits, 200, 1'b0,
                      lat, rd, cs_seen, f_ok, g_ok, o_ok, first_cs);
            check($sformatf("vec%0d_latency", i), 32'(lat),     32'(tbl[i].exp_lat));
            check($sformatf("vec%0d_rdata", i),   rd,           tbl[i].exp_rd);
            check($sformatf("vec%0d_cs", i),      32'(cs_seen), 32'(tbl[i].exp_cs));
            check($sformatf("vec%0d_bus_err", i), 32'(bus_err), 32'(tbl[i].exp_err));
            check($sformatf("vec%0d_wstrb_gate", i), 32'(g_ok), 32'h1);
            if (tbl[i].exp_cs != 3'b000) begin
                check($sformatf("vec%0d_onehot", i), 32'(o_ok), 32'h1);
                check($sformatf("vec%0d_fields", i), 32'(f_ok), 32'h1);
            end
            idle_cycle();
        end

        // Back-to-back: slot0 read then slot2 read with cs held through DONE
        sd[0] = 32'h0BAD_F00D; sd[2] = 32'h7777_1234; load_sdata();
        do_access(16'h0000, 1'b1, 4'hF, 32'h0, 0, 50, 1'b1,
                  lat, rd, cs_seen, f_ok, g_ok, o_ok, first_cs);
        do_access(16'h1000, 1'b1, 4'hF, 32'h0, 0, 50, 1'b0,
                  lat2, rd2, cs_seen2, f_ok, g_ok, o_ok, first_cs2);
        check("b2b_lat1",      32'(lat),       32'd2);
        check("b2b_rd1",       rd,             32'h0BAD_F00D);
        check("b2b_cs1",       32'(cs_seen),   32'h1);
        check("b2b_lat2",      32'(lat2),      32'd3);
        check("b2b_first_cs2", 32'(first_cs2), 32'd2);
        check("b2b_cs2",       32'(cs_seen2),  32'h4);
        check("b2b_rd2",       rd2,            32'h7777_1234);
        check("b2b_onehot2",   32'(o_ok),      32'h1);
        idle_cycle();

        // Random accesses against a transaction-level model
        do_reset();
        m_rd = '0; m_err = 1'b0;
        for (int i = 0; i < 40; i++) begin
            logic [15:0] a;
            logic        oe;
            logic [3:0]  ws;
            logic [31:0] wd;
            int          w, s, exp_lat;
            a = 16'($urandom); oe = 1'($urandom); ws = 4'($urandom); wd = $urandom;
            w = int'($urandom_range(0, 6));
            for (int k = 0; k < NSLAVE; k++) sd[k] = $urandom;
            load_sdata();
            s = (int'(a) >> SEL_LSB) % (2**SEL_W);
            if (s < NSLAVE) begin
                exp_lat = 2 + w;
                if (oe) m_rd = sd[s];
            end else begin
                exp_lat = 1;
                m_rd    = '0;
                m_err   = 1'b1;
            end
            do_access(a, oe, ws, wd, w, 200, 1'b0,
                      lat, rd, cs_seen, f_ok, g_ok, o_ok, first_cs);
            check($sformatf("rnd%0d_latency", i), 32'(lat),     32'(exp_lat));
            check($sformatf("rnd%0d_rdata", i),   rd,           m_rd);
            check($sformatf("rnd%0d_bus_err", i), 32'(bus_err), 32'(m_err));
            if (s < NSLAVE) check($sformatf("rnd%0d_fields", i), 32'(f_ok & o_ok & g_ok), 32'h1);
            idle_cycle();
        end

        // Interrupt synchroniser: 4-cycle pulse on line 1, then random levels
        for (int k = 0; k <= 40; k++) drv[k] = 3'b000;
        for (int k = 1; k <= 4; k++) drv[k] = 3'b010;
        for (int k = 8; k <= 25; k++) drv[k] = 3'($urandom);
        for (int k = 1; k <= 32; k++) begin
            int idx;
            slv_irq = drv[k];
            idle_cycle();
            idx = k - IRQ_STAGES + 1;
            check($sformatf("irq_k%0d", k), 32'(cpu_irq), 32'((idx >= 1) ? drv[idx] : 3'b000));
        end
        slv_irq = '0;

        // Reset in the middle of a stalled slot1 access
        cpu_a = 16'h0800; cpu_oe = 1'b1; cpu_wstrb = 4'hF; cpu_cs = 1'b1; slv_wait = '1;
        idle_cycle();
        check("rstmid_cs_c1", 32'(slv_cs), 32'h2);
        idle_cycle();
        check("rstmid_cs_c2", 32'(slv_cs), 32'h2);
        rst = 1'b1; cpu_cs = 1'b0;
        idle_cycle();
        check("rstmid_cs_off",  32'(slv_cs),    32'h0);
        check("rstmid_wstrb",   32'(slv_wstrb), 32'h0);
        check("rstmid_d_in",    cpu_d_in,       32'h0);
        check("rstmid_bus_err", 32'(bus_err),   32'h0);
        rst = 1'b0;
        idle_cycle();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
